// File: rtl/mdu_seq_pkg.sv
// Shared constants for the multiply/divide sequencer: opcode encodings, FSM states
// and a conditional two's-complement helper.
package mdu_seq_pkg;

  localparam logic [3:0] OP_NONE    = 4'd0;

  localparam logic [3:0] MUL_MUL    = 4'd1;
  localparam logic [3:0] MUL_MULH   = 4'd2;
  localparam logic [3:0] MUL_MULHSU = 4'd3;
  localparam logic [3:0] MUL_MULHU  = 4'd4;

  localparam logic [3:0] DIV_DIV    = 4'd1;
  localparam logic [3:0] DIV_REM    = 4'd2;
  localparam logic [3:0] DIV_DIVU   = 4'd3;
  localparam logic [3:0] DIV_REMU   = 4'd4;

  localparam logic [4:0] DIV_STEPS_M1 = 5'd31;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MUL     = 3'd1,
    S_DIV_RUN = 3'd2,
    S_DIV_FIX = 3'd3,
    S_DONE    = 3'd4
  } mdu_state_t;

  function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] v);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mdu_seq_if.sv
// Execute-stage bundle between the issue logic and the multiply/divide sequencer.
interface mdu_seq_if #(parameter int XLEN = 32);
  logic            start;
  logic [3:0]      mul_op;
  logic [3:0]      div_op;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [4:0]      rd_in;
  logic            flush;
  logic            stall;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;

  modport master (
    output start, mul_op, div_op, rs1_val, rs2_val, rd_in, flush,
    input  stall, busy, done, result, rd_out
  );

  modport slave (
    input  start, mul_op, div_op, rs1_val, rs2_val, rd_in, flush,
    output stall, busy, done, result, rd_out
  );
endinterface

// File: rtl/mdu_seq_div_iter.sv
// Unsigned restoring-divide datapath: loads dividend/divisor, then produces one
// quotient bit per enabled step.
module div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  logic [XLEN-1:0] dvs_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN:0]   shifted;
  logic            fits;
  logic [XLEN-1:0] sub;

  // Partial remainder is always below the divisor, so the wrapped XLEN-bit
  // difference is exact whenever the subtraction is taken.
  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    fits    = (shifted >= {1'b0, dvs_q});
    sub     = shifted[XLEN-1:0] - dvs_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dvs_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
    end else if (load) begin
      dvs_q <= divisor;
      quo_q <= dividend;
      rem_q <= '0;
    end else if (step) begin
      rem_q <= fits ? sub : shifted[XLEN-1:0];
      quo_q <= {quo_q[XLEN-2:0], fits};
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle multiply/divide sequencer. Define MSPU_DIV_EN to build the divider;
// without it, divide ops complete through the multiply timing with a zero result.
//
// state     | meaning
// S_IDLE    | waiting for an op; accepts on start with a nonzero opcode
// S_MUL     | product formed from latched operands
// S_DIV_RUN | one restoring-divide step per cycle, counter 31 down to 0
// S_DIV_FIX | apply result signs or substitute the special-case value
// S_DONE    | result/rd_out valid, done pulse
module mdu_seq
  import mdu_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic       clk,
  input logic       reset,
  mdu_seq_if.slave  bus
);

  mdu_state_t      state_q, state_d;
  logic            op_valid, sel_mul, accept;
  logic            stall_c, busy_c, done_c;

  logic [3:0]      op_q;
  logic            is_div_q;
  logic [XLEN-1:0] a_q, b_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] result_q;
  logic [4:0]      rd_out_q;

  logic [2*XLEN-1:0] a_ext, b_ext, prod;
  logic [XLEN-1:0]   mul_res;

  assign op_valid = (bus.mul_op != OP_NONE) || (bus.div_op != OP_NONE);
  assign sel_mul  = (bus.mul_op != OP_NONE);
  assign accept   = (state_q == S_IDLE) && bus.start && op_valid && !bus.flush;

`ifdef MSPU_DIV_EN
  logic            div_signed, div_rem_in, div_zero, div_ovf, div_special;
  logic [XLEN-1:0] dvd_abs, dvs_abs, spec_res_d;
  logic            neg_q_q, neg_r_q, spec_q;
  logic [XLEN-1:0] spec_res_q;
  logic [4:0]      cnt_q;
  logic [XLEN-1:0] quotient, remainder, div_res;

  // Special cases are resolved at acceptance so they can bypass the iteration.
  always_comb begin
    div_signed  = (bus.div_op == DIV_DIV) || (bus.div_op == DIV_REM);
    div_rem_in  = (bus.div_op == DIV_REM) || (bus.div_op == DIV_REMU);
    dvd_abs     = neg_if(div_signed && bus.rs1_val[XLEN-1], bus.rs1_val);
    dvs_abs     = neg_if(div_signed && bus.rs2_val[XLEN-1], bus.rs2_val);
    div_zero    = (bus.rs2_val == '0);
    div_ovf     = div_signed && (bus.rs1_val == {1'b1, {(XLEN-1){1'b0}}})
                  && (bus.rs2_val == '1);
    div_special = div_zero || div_ovf;
    if (div_zero)
      spec_res_d = div_rem_in ? bus.rs1_val : '1;
    else
      spec_res_d = div_rem_in ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
      spec_q     <= 1'b0;
      spec_res_q <= '0;
      cnt_q      <= '0;
    end else begin
      if (accept && !sel_mul) begin
        neg_q_q    <= div_signed && (bus.rs1_val[XLEN-1] ^ bus.rs2_val[XLEN-1]);
        neg_r_q    <= div_signed && bus.rs1_val[XLEN-1];
        spec_q     <= div_special;
        spec_res_q <= spec_res_d;
        cnt_q      <= DIV_STEPS_M1;
      end else if (state_q == S_DIV_RUN && cnt_q != 5'd0) begin
        cnt_q <= cnt_q - 5'd1;
      end
    end
  end

  div_iter #(.XLEN(XLEN)) u_div_iter (
    .clk       (clk),
    .reset     (reset),
    .load      (accept && !sel_mul),
    .step      (state_q == S_DIV_RUN),
    .dividend  (dvd_abs),
    .divisor   (dvs_abs),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always_comb begin
    if (spec_q)
      div_res = spec_res_q;
    else if (op_q == DIV_REM || op_q == DIV_REMU)
      div_res = neg_if(neg_r_q, remainder);
    else
      div_res = neg_if(neg_q_q, quotient);
  end
`endif

  always_comb begin
    a_ext = (op_q == MUL_MULH || op_q == MUL_MULHSU) ?
            {{XLEN{a_q[XLEN-1]}}, a_q} : {{XLEN{1'b0}}, a_q};
    b_ext = (op_q == MUL_MULH) ? {{XLEN{b_q[XLEN-1]}}, b_q} : {{XLEN{1'b0}}, b_q};
    prod  = a_ext * b_ext;
    mul_res = (op_q == MUL_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    stall_c = 1'b0;
    busy_c  = (state_q != S_IDLE);
    done_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        stall_c = bus.start && op_valid;
        if (accept) begin
          state_d = S_MUL;
`ifdef MSPU_DIV_EN
          if (!sel_mul) state_d = div_special ? S_DIV_FIX : S_DIV_RUN;
`endif
        end
      end
      S_MUL: begin
        stall_c = 1'b1;
        state_d = S_DONE;
      end
`ifdef MSPU_DIV_EN
      S_DIV_RUN: begin
        stall_c = 1'b1;
        if (cnt_q == 5'd0) state_d = S_DIV_FIX;
      end
      S_DIV_FIX: begin
        stall_c = 1'b1;
        state_d = S_DONE;
      end
`endif
      S_DONE: begin
        done_c  = !bus.flush;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (bus.flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q     <= OP_NONE;
      is_div_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      rd_q     <= '0;
    end else if (accept) begin
      op_q     <= sel_mul ? bus.mul_op : bus.div_op;
      is_div_q <= !sel_mul;
      a_q      <= bus.rs1_val;
      b_q      <= bus.rs2_val;
      rd_q     <= bus.rd_in;
    end
  end

  // A flushed op never reaches DONE, so the previous result stays visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= '0;
      rd_out_q <= '0;
    end else if (!bus.flush) begin
      if (state_q == S_MUL) begin
        result_q <= is_div_q ? '0 : mul_res;
        rd_out_q <= rd_q;
      end
`ifdef MSPU_DIV_EN
      if (state_q == S_DIV_FIX) begin
        result_q <= div_res;
        rd_out_q <= rd_q;
      end
`endif
    end
  end

  assign bus.stall  = stall_c;
  assign bus.busy   = busy_c;
  assign bus.done   = done_c;
  assign bus.result = result_q;
  assign bus.rd_out = rd_out_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Directed scoreboard bench for mdu_seq; expectations follow the build's
// MSPU_DIV_EN setting.
module tb_mdu_seq;
  import mdu_seq_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mdu_seq_if #(.XLEN(32)) bus ();
  mdu_seq #(.XLEN(32)) dut (.clk(clk), .reset(reset), .bus(bus));

`ifdef MSPU_DIV_EN
  localparam int DIV_LAT = 34;
  localparam bit DIV_ON  = 1'b1;
`else
  localparam int DIV_LAT = 2;
  localparam bit DIV_ON  = 1'b0;
`endif
  localparam int RST_AT = DIV_ON ? 5 : 1;
  localparam int FL_AT  = DIV_ON ? 10 : 1;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  function automatic logic [31:0] dx(input logic [31:0] v);
    return DIV_ON ? v : 32'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start   = 1'b0;
    bus.mul_op  = OP_NONE;
    bus.div_op  = OP_NONE;
    bus.rs1_val = '0;
    bus.rs2_val = '0;
    bus.rd_in   = '0;
  endtask

  task automatic drive_op(input logic [3:0] m, input logic [3:0] d,
                          input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    bus.start   = 1'b1;
    bus.mul_op  = m;
    bus.div_op  = d;
    bus.rs1_val = a;
    bus.rs2_val = b;
    bus.rd_in   = rd;
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, ".result"}, bus.result, e.res);
      chk({tag, ".rd_out"}, {27'd0, bus.rd_out}, {27'd0, e.rd});
    end
  endtask

  task automatic issue(input string tag, input logic [3:0] m, input logic [3:0] d,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] er, input int lat);
    exp_t e;
    int cyc;
    drive_op(m, d, a, b, rd);
    #1;
    chk({tag, ".stall_T"}, {31'd0, bus.stall}, 32'd1);
    e.res = er;
    e.rd  = rd;
    exp_q.push_back(e);
    step();
    idle_inputs();
    #1;
    chk({tag, ".stall_T1"}, {31'd0, bus.stall}, 32'd1);
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 60) begin
      step();
      cyc++;
    end
    chk({tag, ".latency"}, cyc, lat);
    if (bus.done === 1'b1) begin
      chk({tag, ".stall_done"}, {31'd0, bus.stall}, 32'd0);
      pop_check(tag);
    end else if (exp_q.size() != 0) begin
      void'(exp_q.pop_front());
    end
    step();
    chk({tag, ".done_pulse"}, {31'd0, bus.done}, 32'd0);
    chk({tag, ".idle_after"}, {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    int cyc;
    exp_t e;

    reset     = 1'b1;
    bus.flush = 1'b0;
    idle_inputs();
    step();
    step();
    chk("rst.stall",  {31'd0, bus.stall}, 32'd0);
    chk("rst.busy",   {31'd0, bus.busy},  32'd0);
    chk("rst.done",   {31'd0, bus.done},  32'd0);
    chk("rst.result", bus.result, 32'd0);
    chk("rst.rd_out", {27'd0, bus.rd_out}, 32'd0);
    reset = 1'b0;
    step();

    issue("mul",    MUL_MUL,    OP_NONE, 32'd7,        32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 2);
    issue("mulhu",  MUL_MULHU,  OP_NONE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFE, 2);
    issue("mulh",   MUL_MULH,   OP_NONE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'h0000_0000, 2);
    issue("mulhsu", MUL_MULHSU, OP_NONE, 32'hFFFF_FFFF, 32'd2,         5'd8, 32'hFFFF_FFFF, 2);

    issue("div",    OP_NONE, DIV_DIV,  32'hFFFF_FFEC, 32'd3, 5'd10, dx(32'hFFFF_FFFA), DIV_LAT);
    issue("rem",    OP_NONE, DIV_REM,  32'hFFFF_FFEC, 32'd3, 5'd11, dx(32'hFFFF_FFFE), DIV_LAT);
    issue("divu",   OP_NONE, DIV_DIVU, 32'd100,       32'd7, 5'd12, dx(32'd14),         DIV_LAT);
    issue("remu",   OP_NONE, DIV_REMU, 32'd100,       32'd7, 5'd13, dx(32'd2),          DIV_LAT);

    issue("div0",   OP_NONE, DIV_DIV, 32'd5,         32'd0,         5'd14, dx(32'hFFFF_FFFF), 2);
    issue("rem0",   OP_NONE, DIV_REM, 32'd5,         32'd0,         5'd15, dx(32'd5),         2);
    issue("divovf", OP_NONE, DIV_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, dx(32'h8000_0000), 2);
    issue("removf", OP_NONE, DIV_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, dx(32'd0),         2);

    issue("both",   MUL_MUL, DIV_DIV, 32'd7, 32'd3, 5'd18, 32'd21, 2);

    // reset in the middle of an op: outputs clear, no done afterwards
    drive_op(OP_NONE, DIV_DIVU, 32'd100, 32'd7, 5'd9);
    step();
    idle_inputs();
    repeat (RST_AT - 1) step();
    reset = 1'b1;
    step();
    chk("midrst.done",   {31'd0, bus.done},  32'd0);
    chk("midrst.stall",  {31'd0, bus.stall}, 32'd0);
    chk("midrst.busy",   {31'd0, bus.busy},  32'd0);
    chk("midrst.result", bus.result, 32'd0);
    chk("midrst.rd_out", {27'd0, bus.rd_out}, 32'd0);
    reset = 1'b0;
    ndone = 0;
    repeat (40) begin
      step();
      if (bus.done === 1'b1) ndone++;
    end
    chk("midrst.no_done", ndone, 0);

    // flush mid-op, then a multiply issued the very next cycle
    drive_op(OP_NONE, DIV_DIVU, 32'd100, 32'd7, 5'd20);
    step();
    idle_inputs();
    ndone = 0;
    repeat (FL_AT - 1) begin
      step();
      if (bus.done === 1'b1) ndone++;
    end
    bus.flush = 1'b1;
    #1;
    if (bus.done === 1'b1) ndone++;
    step();
    bus.flush = 1'b0;
    #1;
    chk("flush.idle", {31'd0, bus.busy}, 32'd0);
    chk("flush.no_done", ndone, 0);
    chk("flush.result_kept", bus.result, 32'd0);
    issue("flush.mul", MUL_MUL, OP_NONE, 32'd6, 32'd9, 5'd21, 32'd54, 2);

    // flush in the accept cycle cancels the accept
    drive_op(MUL_MUL, OP_NONE, 32'd3, 32'd3, 5'd22);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    idle_inputs();
    #1;
    chk("flush_acc.busy", {31'd0, bus.busy}, 32'd0);
    step();
    chk("flush_acc.done", {31'd0, bus.done}, 32'd0);
    chk("flush_acc.result", bus.result, 32'd54);

    // start held through the whole op is not re-accepted
    e.res = dx(32'd14);
    e.rd  = 5'd23;
    exp_q.push_back(e);
    drive_op(OP_NONE, DIV_DIVU, 32'd100, 32'd7, 5'd23);
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 60) begin
      step();
      cyc++;
    end
    chk("held.latency", cyc, DIV_LAT);
    if (bus.done === 1'b1) pop_check("held");
    idle_inputs();
    step();
    chk("held.done_pulse", {31'd0, bus.done}, 32'd0);
    chk("held.idle", {31'd0, bus.busy}, 32'd0);
    chk("held.sb_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdu_seq.md
# mdu_seq

Multi-cycle multiply/divide sequencer for the M-extension ops emitted by the instruction decoder (`mul_op`, `div_op`). Sits beside the ALU in the execute stage. Latches operands on issue, runs a 2-cycle multiply or a 32-iteration restoring divide, and holds the pipeline with `stall` until the result is ready. Returns a single-cycle `done` pulse with the result and destination register.

## Interface
- `XLEN`, default 32, operand/result width; only 32 is supported.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  decode/execute presents an instruction this cycle.
- `mul_op`  in  4  multiply opcode from the decoder; 0 = none.
- `div_op`  in  4  divide opcode from the decoder; 0 = none.
- `rs1_val`  in  XLEN  operand A, forwarded value.
- `rs2_val`  in  XLEN  operand B, forwarded value.
- `rd_in`  in  5  destination register.
- `flush`  in  1  kill the in-flight op (branch mispredict/trap).
- `stall`  out  1  hold the fetch/decode/execute stages.
- `busy`  out  1  FSM is not in IDLE.
- `done`  out  1  result valid, one-cycle pulse.
- `result`  out  XLEN  result; valid only while `done` is high.
- `rd_out`  out  5  destination for `result`.

One clock; reset is synchronous and active-high.

## Operation
- Encodings:
  - `MUL_MUL`=1, `MUL_MULH`=2, `MUL_MULHSU`=3, `MUL_MULHU`=4.
  - `DIV_DIV`=1, `DIV_REM`=2, `DIV_DIVU`=3, `DIV_REMU`=4.
- Op is accepted only in IDLE with `start` high and a nonzero opcode. Operands, op and `rd_in` are registered on acceptance.
- If both opcodes are nonzero, the multiply executes and `div_op` is ignored.
- FSM states:
  - IDLE: on accept, go to MUL or DIV_RUN.
  - MUL: go to DONE.
  - DIV_RUN: counts 31 down to 0; go to DIV_FIX at 0.
  - DIV_FIX: go to DONE.
  - DONE: go to IDLE.
- Multiply:
  - Form the 64-bit product with per-op sign extension: MULH is signed×signed, MULHSU is signed×unsigned, MULHU is unsigned×unsigned.
  - MUL returns the low 32 bits; the others return the high 32 bits.
- Divide:
  - Signed ops take absolute values at acceptance, then run an unsigned restoring divide, one quotient bit per cycle.
  - DIV_FIX applies signs: quotient is negated if the operand signs differ; remainder takes the dividend's sign.
- Special cases are detected at acceptance and skip DIV_RUN (IDLE→DIV_FIX):
  - Divisor 0: quotient = 0xFFFF_FFFF, remainder = dividend.
  - Signed 0x8000_0000 / 0xFFFF_FFFF: quotient = 0x8000_0000, remainder = 0.
- `stall` = (IDLE & `start` & opcode≠0) | MUL | DIV_RUN | DIV_FIX. `stall` is low in DONE, so the held instruction retires on the `done` cycle.
- `start` is ignored outside IDLE.
- `flush` in any state: next state IDLE, no `done`, `result` unchanged. Flush in the accept cycle cancels the accept.
- Reset values: state IDLE, `stall`=0, `busy`=0, `done`=0, `result`=0, `rd_out`=0, counter=0. Reset mid-op aborts with no `done`.

## Timing
- Accept at cycle T.
  - Multiply: `done` at T+2.
  - Normal divide: T+1..T+32 in DIV_RUN, DIV_FIX at T+33, `done` at T+34.
  - Special-case divide: `done` at T+2.
- `done` lasts exactly one cycle. `result`/`rd_out` are registered and stable during `done`.
- Back-to-back ops: the next accept is no earlier than the cycle after DONE (IDLE). Issue spacing: 3 cycles for multiply, 35 for normal divide.
- `stall` is combinational from `start`/opcodes in IDLE and registered state otherwise. There is no combinational path from `rs*_val` to `stall`.

## Configuration
- `MSPU_DIV_EN` defined: divider sub-module and the DIV_RUN/DIV_FIX states are built.
- `MSPU_DIV_EN` undefined:
  - A nonzero `div_op` is accepted and goes IDLE→DONE with `result`=0, `done` at T+2 (routed through MUL timing).
  - The divider is not instantiated.

## Structure
- `MUL_*`/`DIV_*` encodings and the FSM state enum belong in the shared core constants header included by the decoder.
- One sub-module, `div_iter`: the restoring-divide datapath (remainder/quotient shift registers, one step per enable).
- `mdu_seq` owns the FSM, counter, sign handling, multiplier and stall logic.

## Test plan
- MUL 7×-3 (0x7, 0xFFFF_FFFD), rd=5 → `done` at T+2, `result`=0xFFFF_FFEB, `rd_out`=5; `stall` high T..T+1, low at T+2.
- MULHU 0xFFFF_FFFF×0xFFFF_FFFF → 0xFFFF_FFFE; MULH same operands → 0x0000_0000; MULHSU 0xFFFF_FFFF×2 → 0xFFFF_FFFF.
- DIV -20/3 → `done` at T+34, 0xFFFF_FFFA; REM -20/3 → 0xFFFF_FFFE; DIVU 100/7 → 14.
- DIV 5/0 → 0xFFFF_FFFF at T+2; REM 5/0 → 5; DIV 0x8000_0000/0xFFFF_FFFF → 0x8000_0000; REM of the same → 0.
- Divide accepted, `flush` at T+10 → IDLE at T+11, no `done`; a new MUL accepted at T+11 → `done` at T+13.
- `reset` at T+5 of a divide → all outputs 0 next cycle; `start` held during DIV_RUN is not re-accepted; a `MSPU_DIV_EN`-undefined build returns 0 at T+2.
